// File: rtl/riscv_operand_fetch_if.sv
// Bus bundle between fetch, register file, forwarding network and the EX stage
// for the RV32I operand-fetch stage. The DUT uses the slave modport.
interface riscv_operand_fetch_if #(
    parameter int XLEN = 32
);
    // Control and fetch side
    logic            i_flush;
    logic            i_if_valid;
    logic [31:0]     i_if_instr;
    logic [XLEN-1:0] i_if_pc;
    logic            o_if_ready;

    // Register file read port
    logic [4:0]      o_regfile_rs1_addr;
    logic [4:0]      o_regfile_rs2_addr;
    logic [XLEN-1:0] i_regfile_rs1_data;
    logic [XLEN-1:0] i_regfile_rs2_data;

    // Forwarding sources from downstream stages
    logic            i_ex_fwd_wen;
    logic            i_ex_fwd_is_load;
    logic [4:0]      i_ex_fwd_addr;
    logic [XLEN-1:0] i_ex_fwd_data;
    logic            i_mem_fwd_wen;
    logic [4:0]      i_mem_fwd_addr;
    logic [XLEN-1:0] i_mem_fwd_data;
    logic            i_wb_fwd_wen;
    logic [4:0]      i_wb_fwd_addr;
    logic [XLEN-1:0] i_wb_fwd_data;

    // ID/EX pipeline register
    logic            o_ex_valid;
    logic            i_ex_ready;
    logic [31:0]     o_ex_instr;
    logic [XLEN-1:0] o_ex_pc;
    logic [XLEN-1:0] o_ex_rs1_data;
    logic [XLEN-1:0] o_ex_rs2_data;

    modport master (
        output i_flush, i_if_valid, i_if_instr, i_if_pc,
        input  o_if_ready,
        input  o_regfile_rs1_addr, o_regfile_rs2_addr,
        output i_regfile_rs1_data, i_regfile_rs2_data,
        output i_ex_fwd_wen, i_ex_fwd_is_load, i_ex_fwd_addr, i_ex_fwd_data,
        output i_mem_fwd_wen, i_mem_fwd_addr, i_mem_fwd_data,
        output i_wb_fwd_wen, i_wb_fwd_addr, i_wb_fwd_data,
        input  o_ex_valid,
        output i_ex_ready,
        input  o_ex_instr, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data
    );

    modport slave (
        input  i_flush, i_if_valid, i_if_instr, i_if_pc,
        output o_if_ready,
        output o_regfile_rs1_addr, o_regfile_rs2_addr,
        input  i_regfile_rs1_data, i_regfile_rs2_data,
        input  i_ex_fwd_wen, i_ex_fwd_is_load, i_ex_fwd_addr, i_ex_fwd_data,
        input  i_mem_fwd_wen, i_mem_fwd_addr, i_mem_fwd_data,
        input  i_wb_fwd_wen, i_wb_fwd_addr, i_wb_fwd_data,
        output o_ex_valid,
        input  i_ex_ready,
        output o_ex_instr, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data
    );
endinterface

// File: rtl/riscv_operand_fetch.sv
// RV32I decode/operand-read stage: drives regfile read addresses, merges EX/MEM/WB
// bypass data, detects load-use hazards and fills the ID/EX pipeline register.
module riscv_operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    riscv_operand_fetch_if.slave bus
);
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INSTR_NOP  = 32'h00000013;

    logic [6:0]      opcode;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_used;
    logic            rs2_used;
    logic            ex_load_pending;
    logic            hazard;
    logic            adv;
    logic            capture;
    logic [XLEN-1:0] rs1_resolved;
    logic [XLEN-1:0] rs2_resolved;

    logic            ex_valid_q;
    logic [31:0]     ex_instr_q;
    logic [XLEN-1:0] ex_pc_q;
    logic [XLEN-1:0] ex_rs1_q;
    logic [XLEN-1:0] ex_rs2_q;

    // First-match bypass priority: x0, EX (non-load), MEM, WB, then regfile.
    // WB must be bypassed because the regfile only updates at the clock edge.
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_wen,
        input logic            ex_is_load,
        input logic [4:0]      ex_addr,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_wen,
        input logic [4:0]      mem_addr,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_wen,
        input logic [4:0]      wb_addr,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] result;
        if (addr == 5'd0)
            result = '0;
        else if (ex_wen && !ex_is_load && (ex_addr == addr))
            result = ex_data;
        else if (mem_wen && (mem_addr == addr))
            result = mem_data;
        else if (wb_wen && (wb_addr == addr))
            result = wb_data;
        else
            result = rf_data;
        return result;
    endfunction

    assign opcode   = bus.i_if_instr[6:0];
    assign rs1_addr = bus.i_if_instr[19:15];
    assign rs2_addr = bus.i_if_instr[24:20];

    assign bus.o_regfile_rs1_addr = rs1_addr;
    assign bus.o_regfile_rs2_addr = rs2_addr;

    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL:   rs1_used = 1'b0;
            default:                       rs1_used = 1'b1;
        endcase
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: rs2_used = 1'b1;
            default:                       rs2_used = 1'b0;
        endcase
    end

    always_comb begin
        rs1_resolved = resolve_operand(rs1_addr, bus.i_regfile_rs1_data,
                                       bus.i_ex_fwd_wen, bus.i_ex_fwd_is_load,
                                       bus.i_ex_fwd_addr, bus.i_ex_fwd_data,
                                       bus.i_mem_fwd_wen, bus.i_mem_fwd_addr,
                                       bus.i_mem_fwd_data,
                                       bus.i_wb_fwd_wen, bus.i_wb_fwd_addr,
                                       bus.i_wb_fwd_data);
        rs2_resolved = resolve_operand(rs2_addr, bus.i_regfile_rs2_data,
                                       bus.i_ex_fwd_wen, bus.i_ex_fwd_is_load,
                                       bus.i_ex_fwd_addr, bus.i_ex_fwd_data,
                                       bus.i_mem_fwd_wen, bus.i_mem_fwd_addr,
                                       bus.i_mem_fwd_data,
                                       bus.i_wb_fwd_wen, bus.i_wb_fwd_addr,
                                       bus.i_wb_fwd_data);
    end

    // A load in EX cannot be bypassed yet; one bubble lets it reach MEM.
    assign ex_load_pending = bus.i_ex_fwd_wen && bus.i_ex_fwd_is_load &&
                             (bus.i_ex_fwd_addr != 5'd0);
    assign hazard = bus.i_if_valid && ex_load_pending &&
                    ((rs1_used && (rs1_addr == bus.i_ex_fwd_addr)) ||
                     (rs2_used && (rs2_addr == bus.i_ex_fwd_addr)));

    // Handshake: a side transfers on a cycle where valid and ready are both high at
    // the rising edge; ready never waits on valid from the same side. Flush makes
    // the stage ready so the offered instruction is consumed and discarded.
    assign adv     = !ex_valid_q || bus.i_ex_ready;
    assign capture = adv && bus.i_if_valid && !hazard;

    assign bus.o_if_ready = bus.i_flush || (adv && !hazard);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= INSTR_NOP;
            ex_pc_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else if (bus.i_flush) begin
            ex_valid_q <= 1'b0;
        end else if (adv) begin
            ex_valid_q <= capture;
            if (capture) begin
                ex_instr_q <= bus.i_if_instr;
                ex_pc_q    <= bus.i_if_pc;
                ex_rs1_q   <= rs1_resolved;
                ex_rs2_q   <= rs2_resolved;
            end
        end
    end

    assign bus.o_ex_valid    = ex_valid_q;
    assign bus.o_ex_instr    = ex_instr_q;
    assign bus.o_ex_pc       = ex_pc_q;
    assign bus.o_ex_rs1_data = ex_rs1_q;
    assign bus.o_ex_rs2_data = ex_rs2_q;
endmodule

// File: tb/tb_riscv_operand_fetch.sv
// Bench for riscv_operand_fetch: directed scenarios plus a randomized run against a
// behavioural model of the ID/EX register built from the stage's rules.
module tb_riscv_operand_fetch;
    localparam int XLEN = 32;
    localparam logic [6:0] OP_R = 7'b0110011;

    logic i_clk = 1'b0;
    logic i_rst;

    riscv_operand_fetch_if #(.XLEN(XLEN)) bus ();

    riscv_operand_fetch #(.XLEN(XLEN)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the ID/EX register
    logic            m_valid;
    logic [31:0]     m_instr;
    logic [XLEN-1:0] m_pc;
    logic [XLEN-1:0] m_rs1;
    logic [XLEN-1:0] m_rs2;

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, OP_R};
    endfunction

    function automatic bit spec_uses_rs1(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic bit spec_uses_rs2(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    // Forwarding sources listed in priority order; a load in EX is not a source.
    function automatic logic [XLEN-1:0] spec_operand(input logic [4:0] a,
                                                     input logic [XLEN-1:0] rf);
        logic            fw [3];
        logic [4:0]      fa [3];
        logic [XLEN-1:0] fd [3];
        fw[0] = bus.i_ex_fwd_wen && !bus.i_ex_fwd_is_load;
        fa[0] = bus.i_ex_fwd_addr;  fd[0] = bus.i_ex_fwd_data;
        fw[1] = bus.i_mem_fwd_wen;
        fa[1] = bus.i_mem_fwd_addr; fd[1] = bus.i_mem_fwd_data;
        fw[2] = bus.i_wb_fwd_wen;
        fa[2] = bus.i_wb_fwd_addr;  fd[2] = bus.i_wb_fwd_data;
        if (a == 5'd0) return '0;
        for (int k = 0; k < 3; k++)
            if (fw[k] && fa[k] == a) return fd[k];
        return rf;
    endfunction

    function automatic bit spec_hazard();
        logic [31:0] ins;
        bit load_dest;
        ins = bus.i_if_instr;
        load_dest = bus.i_ex_fwd_wen && bus.i_ex_fwd_is_load && bus.i_ex_fwd_addr != 5'd0;
        if (!bus.i_if_valid || !load_dest) return 1'b0;
        return (spec_uses_rs1(ins) && ins[19:15] == bus.i_ex_fwd_addr) ||
               (spec_uses_rs2(ins) && ins[24:20] == bus.i_ex_fwd_addr);
    endfunction

    function automatic bit spec_ready();
        return bus.i_flush || ((!m_valid || bus.i_ex_ready) && !spec_hazard());
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = 32'h00000013;
        m_pc    = '0;
        m_rs1   = '0;
        m_rs2   = '0;
    endtask

    task automatic set_idle();
        bus.i_flush = 0; bus.i_if_valid = 0; bus.i_if_instr = 32'h00000013; bus.i_if_pc = '0;
        bus.i_regfile_rs1_data = '0; bus.i_regfile_rs2_data = '0;
        bus.i_ex_fwd_wen = 0; bus.i_ex_fwd_is_load = 0; bus.i_ex_fwd_addr = '0; bus.i_ex_fwd_data = '0;
        bus.i_mem_fwd_wen = 0; bus.i_mem_fwd_addr = '0; bus.i_mem_fwd_data = '0;
        bus.i_wb_fwd_wen = 0; bus.i_wb_fwd_addr = '0; bus.i_wb_fwd_data = '0;
        bus.i_ex_ready = 1;
    endtask

    // Advance the model with the current inputs and step one clock edge.
    task automatic tick();
        logic            nv;
        logic [31:0]     ni;
        logic [XLEN-1:0] np, n1, n2;
        nv = m_valid; ni = m_instr; np = m_pc; n1 = m_rs1; n2 = m_rs2;
        if (bus.i_flush) begin
            nv = 1'b0;
        end else if (!m_valid || bus.i_ex_ready) begin
            if (bus.i_if_valid && !spec_hazard()) begin
                nv = 1'b1;
                ni = bus.i_if_instr;
                np = bus.i_if_pc;
                n1 = spec_operand(bus.i_if_instr[19:15], bus.i_regfile_rs1_data);
                n2 = spec_operand(bus.i_if_instr[24:20], bus.i_regfile_rs2_data);
            end else begin
                nv = 1'b0;
            end
        end
        @(posedge i_clk);
        #1;
        m_valid = nv; m_instr = ni; m_pc = np; m_rs1 = n1; m_rs2 = n2;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.o_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b exp 0", bus.o_ex_valid); end
        checks++; if (bus.o_ex_instr !== 32'h00000013) begin errors++; $display("FAIL reset_instr: got %h exp 00000013", bus.o_ex_instr); end
        checks++; if (bus.o_ex_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h exp 0", bus.o_ex_pc); end
        checks++; if (bus.o_ex_rs1_data !== '0 || bus.o_ex_rs2_data !== '0) begin errors++; $display("FAIL reset_ops: got %h/%h exp 0/0", bus.o_ex_rs1_data, bus.o_ex_rs2_data); end
        checks++; if (bus.o_if_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", bus.o_if_ready); end
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_bypass_priority();
        @(negedge i_clk);
        set_idle();
        bus.i_if_valid = 1; bus.i_if_instr = r_type(5'd1, 5'd5, 5'd0); bus.i_if_pc = 32'h100;
        bus.i_regfile_rs1_data = 32'h1;
        bus.i_ex_fwd_wen = 1;  bus.i_ex_fwd_addr = 5'd5;  bus.i_ex_fwd_data = 32'hAAAA0000;
        bus.i_mem_fwd_wen = 1; bus.i_mem_fwd_addr = 5'd5; bus.i_mem_fwd_data = 32'h0000BBBB;
        bus.i_wb_fwd_wen = 1;  bus.i_wb_fwd_addr = 5'd5;  bus.i_wb_fwd_data = 32'h0000CCCC;
        #1;
        checks++; if (bus.o_regfile_rs1_addr !== 5'd5) begin errors++; $display("FAIL bypass_rs1_addr: got %0d exp 5", bus.o_regfile_rs1_addr); end
        tick();
        checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_rs1_data !== 32'hAAAA0000) begin errors++; $display("FAIL bypass_ex: got v=%0b %h exp v=1 aaaa0000", bus.o_ex_valid, bus.o_ex_rs1_data); end
        @(negedge i_clk); bus.i_ex_fwd_wen = 0;
        tick();
        checks++; if (bus.o_ex_rs1_data !== 32'h0000BBBB) begin errors++; $display("FAIL bypass_mem: got %h exp 0000bbbb", bus.o_ex_rs1_data); end
        @(negedge i_clk); bus.i_mem_fwd_wen = 0;
        tick();
        checks++; if (bus.o_ex_rs1_data !== 32'h0000CCCC) begin errors++; $display("FAIL bypass_wb: got %h exp 0000cccc", bus.o_ex_rs1_data); end
        @(negedge i_clk); bus.i_wb_fwd_wen = 0;
        tick();
        checks++; if (bus.o_ex_rs1_data !== 32'h1) begin errors++; $display("FAIL bypass_regfile: got %h exp 00000001", bus.o_ex_rs1_data); end
    endtask

    task automatic test_x0();
        @(negedge i_clk);
        set_idle();
        bus.i_if_valid = 1; bus.i_if_instr = r_type(5'd1, 5'd0, 5'd0); bus.i_if_pc = 32'h110;
        bus.i_regfile_rs1_data = 32'hFFFFFFFF; bus.i_regfile_rs2_data = 32'hFFFFFFFF;
        bus.i_ex_fwd_wen = 1; bus.i_ex_fwd_is_load = 1; bus.i_ex_fwd_addr = 5'd0; bus.i_ex_fwd_data = 32'hFFFFFFFF;
        bus.i_mem_fwd_wen = 1; bus.i_mem_fwd_addr = 5'd0; bus.i_mem_fwd_data = 32'hFFFFFFFF;
        bus.i_wb_fwd_wen = 1; bus.i_wb_fwd_addr = 5'd0; bus.i_wb_fwd_data = 32'hFFFFFFFF;
        #1;
        checks++; if (bus.o_if_ready !== 1'b1) begin errors++; $display("FAIL x0_no_hazard: got %0b exp 1", bus.o_if_ready); end
        tick();
        checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_rs1_data !== '0 || bus.o_ex_rs2_data !== '0) begin errors++; $display("FAIL x0_operands: got v=%0b %h/%h exp v=1 0/0", bus.o_ex_valid, bus.o_ex_rs1_data, bus.o_ex_rs2_data); end
    endtask

    task automatic test_load_use();
        @(negedge i_clk);
        set_idle();
        bus.i_if_valid = 1; bus.i_if_instr = r_type(5'd8, 5'd7, 5'd1); bus.i_if_pc = 32'h120;
        bus.i_regfile_rs1_data = 32'h99; bus.i_regfile_rs2_data = 32'h11;
        bus.i_ex_fwd_wen = 1; bus.i_ex_fwd_is_load = 1; bus.i_ex_fwd_addr = 5'd7; bus.i_ex_fwd_data = 32'hDEAD;
        #1;
        checks++; if (bus.o_if_ready !== 1'b0) begin errors++; $display("FAIL load_use_stall: got %0b exp 0", bus.o_if_ready); end
        tick();
        checks++; if (bus.o_ex_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble: got %0b exp 0", bus.o_ex_valid); end
        @(negedge i_clk);
        bus.i_ex_fwd_wen = 0; bus.i_ex_fwd_is_load = 0;
        bus.i_mem_fwd_wen = 1; bus.i_mem_fwd_addr = 5'd7; bus.i_mem_fwd_data = 32'h55;
        #1;
        checks++; if (bus.o_if_ready !== 1'b1) begin errors++; $display("FAIL load_use_release: got %0b exp 1", bus.o_if_ready); end
        tick();
        checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_rs1_data !== 32'h55 || bus.o_ex_rs2_data !== 32'h11) begin errors++; $display("FAIL load_use_bypass: got v=%0b %h/%h exp v=1 55/11", bus.o_ex_valid, bus.o_ex_rs1_data, bus.o_ex_rs2_data); end
    endtask

    task automatic test_no_false_hazard();
        @(negedge i_clk);
        set_idle();
        bus.i_if_valid = 1; bus.i_if_instr = {12'h000, 5'd7, 3'd0, 5'd7, 7'b0110111}; bus.i_if_pc = 32'h130;
        bus.i_ex_fwd_wen = 1; bus.i_ex_fwd_is_load = 1; bus.i_ex_fwd_addr = 5'd7;
        #1;
        checks++; if (bus.o_if_ready !== 1'b1) begin errors++; $display("FAIL lui_no_stall: got %0b exp 1", bus.o_if_ready); end
        tick();
        checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_instr !== {12'h000, 5'd7, 3'd0, 5'd7, 7'b0110111}) begin errors++; $display("FAIL lui_capture: got v=%0b %h exp v=1 000383b7", bus.o_ex_valid, bus.o_ex_instr); end
    endtask

    task automatic test_backpressure();
        @(negedge i_clk);
        set_idle();
        bus.i_if_valid = 1; bus.i_if_instr = r_type(5'd3, 5'd2, 5'd4); bus.i_if_pc = 32'h200;
        bus.i_regfile_rs1_data = 32'h1111; bus.i_regfile_rs2_data = 32'h2222;
        tick();
        @(negedge i_clk);
        bus.i_ex_ready = 0;
        bus.i_if_instr = r_type(5'd9, 5'd6, 5'd10); bus.i_if_pc = 32'h204;
        bus.i_regfile_rs1_data = 32'h3333; bus.i_regfile_rs2_data = 32'h4444;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge i_clk);
            #1;
            checks++; if (bus.o_if_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b exp 0", i, bus.o_if_ready); end
            tick();
            checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_instr !== r_type(5'd3, 5'd2, 5'd4) || bus.o_ex_pc !== 32'h200 || bus.o_ex_rs1_data !== 32'h1111 || bus.o_ex_rs2_data !== 32'h2222) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%0b %h pc=%h %h/%h exp held A", i, bus.o_ex_valid, bus.o_ex_instr, bus.o_ex_pc, bus.o_ex_rs1_data, bus.o_ex_rs2_data);
            end
        end
        @(negedge i_clk);
        bus.i_ex_ready = 1;
        #1;
        checks++; if (bus.o_if_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0b exp 1", bus.o_if_ready); end
        tick();
        checks++; if (bus.o_ex_valid !== 1'b1 || bus.o_ex_instr !== r_type(5'd9, 5'd6, 5'd10) || bus.o_ex_pc !== 32'h204 || bus.o_ex_rs1_data !== 32'h3333) begin
            errors++; $display("FAIL bp_next: got v=%0b %h pc=%h rs1=%h exp B", bus.o_ex_valid, bus.o_ex_instr, bus.o_ex_pc, bus.o_ex_rs1_data);
        end
    endtask

    task automatic test_flush_hazard();
        @(negedge i_clk);
        set_idle();
        bus.i_if_valid = 1; bus.i_if_instr = r_type(5'd3, 5'd2, 5'd4); bus.i_if_pc = 32'h300;
        tick();
        @(negedge i_clk);
        bus.i_ex_ready = 0; bus.i_flush = 1;
        bus.i_if_instr = r_type(5'd8, 5'd7, 5'd1); bus.i_if_pc = 32'h304;
        bus.i_ex_fwd_wen = 1; bus.i_ex_fwd_is_load = 1; bus.i_ex_fwd_addr = 5'd7;
        #1;
        checks++; if (bus.o_if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b exp 1", bus.o_if_ready); end
        tick();
        checks++; if (bus.o_ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b exp 0", bus.o_ex_valid); end
        @(negedge i_clk);
        bus.i_flush = 0;
        #1;
        checks++; if (bus.o_if_ready !== 1'b0) begin errors++; $display("FAIL flush_then_hazard: got %0b exp 0", bus.o_if_ready); end
    endtask

    task automatic test_async_reset_mid_stall();
        @(negedge i_clk);
        set_idle();
        bus.i_if_valid = 1; bus.i_if_instr = r_type(5'd3, 5'd2, 5'd4); bus.i_if_pc = 32'h400;
        bus.i_regfile_rs1_data = 32'h5; bus.i_regfile_rs2_data = 32'h6;
        tick();
        @(negedge i_clk);
        bus.i_ex_ready = 0;
        tick();
        checks++; if (bus.o_ex_valid !== 1'b1) begin errors++; $display("FAIL stall_before_reset: got %0b exp 1", bus.o_ex_valid); end
        @(negedge i_clk);
        #1 i_rst = 1'b1;
        #1;
        checks++; if (bus.o_ex_valid !== 1'b0 || bus.o_ex_instr !== 32'h00000013 || bus.o_ex_pc !== '0) begin
            errors++; $display("FAIL async_reset: got v=%0b %h pc=%h exp v=0 00000013 pc=0", bus.o_ex_valid, bus.o_ex_instr, bus.o_ex_pc);
        end
        model_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        set_idle();
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        logic [31:0] w;
        bit accepted;
        logic [XLEN-1:0] pc;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b0100011, 7'b1100011, 7'b0000011, 7'b1100111};
        accepted = 1'b1;
        pc = 32'h1000;
        @(negedge i_clk);
        set_idle();
        for (int n = 0; n < 500; n++) begin
            if (n > 0) @(negedge i_clk);
            if (accepted || !bus.i_if_valid) begin
                w = $urandom;
                w[6:0] = ops[$urandom_range(0, 8)];
                w[19:15] = 5'($urandom_range(0, 3));
                w[24:20] = 5'($urandom_range(0, 3));
                bus.i_if_instr = w;
                bus.i_if_valid = ($urandom_range(0, 3) != 0);
                pc = pc + 4;
                bus.i_if_pc = pc;
            end
            bus.i_flush = ($urandom_range(0, 15) == 0);
            bus.i_ex_ready = ($urandom_range(0, 3) != 0);
            bus.i_regfile_rs1_data = $urandom; bus.i_regfile_rs2_data = $urandom;
            bus.i_ex_fwd_wen = 1'($urandom_range(0, 1)); bus.i_ex_fwd_is_load = 1'($urandom_range(0, 1));
            bus.i_ex_fwd_addr = 5'($urandom_range(0, 3)); bus.i_ex_fwd_data = $urandom;
            bus.i_mem_fwd_wen = 1'($urandom_range(0, 1));
            bus.i_mem_fwd_addr = 5'($urandom_range(0, 3)); bus.i_mem_fwd_data = $urandom;
            bus.i_wb_fwd_wen = 1'($urandom_range(0, 1));
            bus.i_wb_fwd_addr = 5'($urandom_range(0, 3)); bus.i_wb_fwd_data = $urandom;
            #1;
            checks++; if (bus.o_if_ready !== spec_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %0b exp %0b", n, bus.o_if_ready, spec_ready()); end
            checks++; if (bus.o_regfile_rs1_addr !== bus.i_if_instr[19:15] || bus.o_regfile_rs2_addr !== bus.i_if_instr[24:20]) begin
                errors++; $display("FAIL rand_rf_addr[%0d]: got %0d/%0d exp %0d/%0d", n, bus.o_regfile_rs1_addr, bus.o_regfile_rs2_addr, bus.i_if_instr[19:15], bus.i_if_instr[24:20]);
            end
            accepted = bus.i_if_valid && spec_ready();
            tick();
            checks++; if (bus.o_ex_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %0b exp %0b", n, bus.o_ex_valid, m_valid); end
            if (m_valid) begin
                checks++; if (bus.o_ex_instr !== m_instr || bus.o_ex_pc !== m_pc || bus.o_ex_rs1_data !== m_rs1 || bus.o_ex_rs2_data !== m_rs2) begin
                    errors++; $display("FAIL rand_data[%0d]: got %h pc=%h %h/%h exp %h pc=%h %h/%h", n, bus.o_ex_instr, bus.o_ex_pc, bus.o_ex_rs1_data, bus.o_ex_rs2_data, m_instr, m_pc, m_rs1, m_rs2);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1;
        set_idle();
        model_reset();
        test_reset();
        test_bypass_priority();
        test_x0();
        test_load_use();
        test_no_false_hazard();
        test_backpressure();
        test_flush_hazard();
        test_async_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
